// File: rtl/ddr_instr_pkg.sv
// Shared definitions for the DDR command <-> 32-bit instruction format,
// used by both the instruction unpacker and the command-bus packer.
package ddr_instr_pkg;

  localparam int INSTR_W        = 32;
  localparam int OPC_W          = 3;
  localparam int BANK_OFS       = 3;
  localparam int AP_BIT         = 24;
  localparam int HALF_BL_BIT    = 25;
  localparam int SLOTS_PER_BEAT = 4;
  localparam int BEATS_PER_WORD = 4;
  localparam int BEAT_W         = INSTR_W * SLOTS_PER_BEAT;
  localparam int WORD_W         = BEAT_W * BEATS_PER_WORD;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 3'd0,
    OP_PRE  = 3'd1,
    OP_ACT  = 3'd2,
    OP_RD   = 3'd3,
    OP_WR   = 3'd4,
    OP_REF  = 3'd5,
    OP_ZQ   = 3'd6,
    OP_PALL = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FLUSH
  } cap_state_e;

  // Several strobes may be high in one slot; the highest-priority one wins.
  function automatic opcode_e pick_opcode(input logic act, input logic pre,
                                          input logic rd, input logic wr,
                                          input logic refresh, input logic zq,
                                          input logic pall);
    if (act)          return OP_ACT;
    else if (pre)     return OP_PRE;
    else if (rd)      return OP_RD;
    else if (wr)      return OP_WR;
    else if (refresh) return OP_REF;
    else if (zq)      return OP_ZQ;
    else if (pall)    return OP_PALL;
    return OP_NOP;
  endfunction

endpackage

// File: rtl/instr_word_fifo.sv
// Word FIFO holding {last, data}; supports setting the last flag of the
// most recently written entry while it is still queued.
module instr_word_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             mark_last_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count;
  logic [AW-1:0]    tail_idx;
  logic             do_push, do_pop, mark_ok;

  assign count    = wr_q - rd_q;
  assign empty_o  = (wr_q == rd_q);
  assign full_o   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop   = pop_i && !empty_o;
  assign do_push  = push_i && (!full_o || pop_i);
  assign tail_idx = wr_q[AW-1:0] - AW'(1);
  // A sole entry leaving this cycle is already gone as far as marking goes.
  assign mark_ok  = mark_last_i && !empty_o &&
                    !(do_pop && (count == (AW+1)'(1)));

  assign wr_d = do_push ? wr_q + (AW+1)'(1) : wr_q;
  assign rd_d = do_pop  ? rd_q + (AW+1)'(1) : rd_q;

  // NOTE: storage is not reset; the pointers define validity and the head is
  // forced to zero when empty, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    if (mark_ok) mem_q[tail_idx][WIDTH-1] <= 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  assign head_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/ddr_cmd_packer.sv
// Captures the 4-slot DDR4 command bus, re-encodes each slot as a 32-bit
// instruction and streams 512-bit words of 16 instructions on AXI4-Stream.
module ddr_cmd_packer
  import ddr_instr_pkg::*;
#(
  parameter int BG_WIDTH   = 2,
  parameter int BANK_WIDTH = 2,
  parameter int COL_WIDTH  = 10,
  parameter int ROW_WIDTH  = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     capture_en,
  input  logic [3:0]               ddr_write,
  input  logic [3:0]               ddr_read,
  input  logic [3:0]               ddr_pre,
  input  logic [3:0]               ddr_act,
  input  logic [3:0]               ddr_ref,
  input  logic [3:0]               ddr_zq,
  input  logic [3:0]               ddr_nop,
  input  logic [3:0]               ddr_ap,
  input  logic [3:0]               ddr_half_bl,
  input  logic [3:0]               ddr_pall,
  input  logic [4*BG_WIDTH-1:0]    ddr_bg,
  input  logic [4*BANK_WIDTH-1:0]  ddr_bank,
  input  logic [4*COL_WIDTH-1:0]   ddr_col,
  input  logic [4*ROW_WIDTH-1:0]   ddr_row,
  output logic [511:0]             M_AXIS_TDATA,
  output logic                     M_AXIS_TVALID,
  output logic                     M_AXIS_TLAST,
  input  logic                     M_AXIS_TREADY,
  output logic [31:0]              words_sent,
  output logic [15:0]              drop_count
);

  localparam int F_OFS = BANK_OFS + BANK_WIDTH + BG_WIDTH;
  localparam int ASM_W = WORD_W - BEAT_W;

  logic [BEAT_W-1:0] beat_instr;

  // An idle slot encodes to all zeros whether or not its NOP strobe is set.
  logic unused_nop;
  assign unused_nop = ^ddr_nop;

  for (genvar g = 0; g < SLOTS_PER_BEAT; g++) begin : g_slot
    opcode_e            op;
    logic [INSTR_W-1:0] instr;

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
      op    = pick_opcode(ddr_act[g], ddr_pre[g], ddr_read[g], ddr_write[g],
                          ddr_ref[g], ddr_zq[g], ddr_pall[g]);
      instr = '0;
      if (op != OP_NOP) begin
        instr[OPC_W-1:0]                   = op;
        instr[BANK_OFS +: BANK_WIDTH]      = ddr_bank[g*BANK_WIDTH +: BANK_WIDTH];
        instr[BANK_OFS+BANK_WIDTH +: BG_WIDTH] = ddr_bg[g*BG_WIDTH +: BG_WIDTH];
      end
      case (op)
        OP_ACT: instr[F_OFS +: ROW_WIDTH] = ddr_row[g*ROW_WIDTH +: ROW_WIDTH];
        OP_RD, OP_WR: begin
          instr[F_OFS +: COL_WIDTH] = ddr_col[g*COL_WIDTH +: COL_WIDTH];
          instr[AP_BIT]             = ddr_ap[g];
          instr[HALF_BL_BIT]        = ddr_half_bl[g];
        end
        default: ;
      endcase
    end

    assign beat_instr[g*INSTR_W +: INSTR_W] = instr;
  end

  cap_state_e        state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [ASM_W-1:0]  asm_q, asm_d;
  logic              pushed_q, pushed_d;
  logic [31:0]       words_sent_q, words_sent_d;
  logic [15:0]       drop_q, drop_d;

  logic              capture, push, push_last, mark_last, push_ok, pop;
  logic [WORD_W-1:0] push_data;
  logic              fifo_full, fifo_empty;
  logic [WORD_W:0]   fifo_head;

  assign pop     = !fifo_empty && M_AXIS_TREADY;
  assign push_ok = !fifo_full || pop;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    asm_d     = asm_q;
    pushed_d  = pushed_q;
    capture   = 1'b0;
    push      = 1'b0;
    push_data = '0;
    push_last = 1'b0;
    mark_last = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        pushed_d = 1'b0;
        if (capture_en) begin
          capture = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (capture_en) begin
          capture = 1'b1;
        end else if (beat_q != 2'd0) begin
          state_d = ST_FLUSH;
        end else begin
          // Window closed on a word boundary: tag the last word still queued.
          state_d   = ST_IDLE;
          mark_last = pushed_q;
        end
      end
      ST_FLUSH: begin
        push      = 1'b1;
        push_data = {{BEAT_W{1'b0}}, asm_q};
        push_last = 1'b1;
        asm_d     = '0;
        beat_d    = 2'd0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      if (beat_q == 2'd3) begin
        push      = 1'b1;
        push_data = {beat_instr, asm_q};
        asm_d     = '0;
        beat_d    = 2'd0;
      end else begin
        case (beat_q)
          2'd0:    asm_d[0*BEAT_W +: BEAT_W] = beat_instr;
          2'd1:    asm_d[1*BEAT_W +: BEAT_W] = beat_instr;
          default: asm_d[2*BEAT_W +: BEAT_W] = beat_instr;
        endcase
        beat_d = beat_q + 2'd1;
      end
    end

    if (push && push_ok) pushed_d = 1'b1;
  end

  always_comb begin
    words_sent_d = words_sent_q + {31'd0, pop};
    drop_d       = drop_q;
    if (push && !push_ok && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      beat_q       <= 2'd0;
      asm_q        <= '0;
      pushed_q     <= 1'b0;
      words_sent_q <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      asm_q        <= asm_d;
      pushed_q     <= pushed_d;
      words_sent_q <= words_sent_d;
      drop_q       <= drop_d;
    end
  end

  instr_word_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .data_i      ({push_last, push_data}),
    .pop_i       (pop),
    .mark_last_i (mark_last),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  assign M_AXIS_TVALID = !fifo_empty;
  assign M_AXIS_TDATA  = fifo_head[WORD_W-1:0];
  assign M_AXIS_TLAST  = fifo_head[WORD_W];
  assign words_sent    = words_sent_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_ddr_cmd_packer.sv
// Self-checking bench for ddr_cmd_packer: table of slot vectors with
// hand-encoded instructions, scoreboard queue checked at each handshake.
module tb_ddr_cmd_packer;

  localparam int BGW = 2, BKW = 2, CLW = 10, RWW = 17, DEPTH = 4;
  localparam logic [6:0] CA = 7'h01, CP = 7'h02, CR = 7'h04, CW = 7'h08,
                         CF = 7'h10, CZ = 7'h20, CL = 7'h40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, capture_en, M_AXIS_TREADY;
  logic [3:0]       ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq;
  logic [3:0]       ddr_nop, ddr_ap, ddr_half_bl, ddr_pall;
  logic [4*BGW-1:0] ddr_bg;
  logic [4*BKW-1:0] ddr_bank;
  logic [4*CLW-1:0] ddr_col;
  logic [4*RWW-1:0] ddr_row;
  logic [511:0]     M_AXIS_TDATA;
  logic             M_AXIS_TVALID, M_AXIS_TLAST;
  logic [31:0]      words_sent;
  logic [15:0]      drop_count;

  ddr_cmd_packer #(
    .BG_WIDTH(BGW), .BANK_WIDTH(BKW), .COL_WIDTH(CLW), .ROW_WIDTH(RWW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en),
    .ddr_write(ddr_write), .ddr_read(ddr_read), .ddr_pre(ddr_pre),
    .ddr_act(ddr_act), .ddr_ref(ddr_ref), .ddr_zq(ddr_zq), .ddr_nop(ddr_nop),
    .ddr_ap(ddr_ap), .ddr_half_bl(ddr_half_bl), .ddr_pall(ddr_pall),
    .ddr_bg(ddr_bg), .ddr_bank(ddr_bank), .ddr_col(ddr_col), .ddr_row(ddr_row),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .words_sent(words_sent), .drop_count(drop_count)
  );

  typedef struct packed {
    logic [6:0]  cmd;
    logic        nop, ap, hbl;
    logic [1:0]  bg, bank;
    logic [16:0] row;
    logic [9:0]  col;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic         last;
    logic [511:0] data;
  } sb_t;

  vec_t         vecs [16];
  sb_t          sb_q [$];
  sb_t          sb_e;
  logic [511:0] exp_asm;
  int           tb_beat, push_budget;
  int           n_checks = 0, n_fail = 0;
  logic         prev_hold, prev_last;
  logic [511:0] prev_data;

  task automatic check(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] cmd, input logic nop,
                              input logic ap, input logic hbl,
                              input logic [1:0] bg, input logic [1:0] bank,
                              input logic [16:0] row, input logic [9:0] col,
                              input logic [31:0] exp);
    vec_t v;
    v.cmd = cmd; v.nop = nop; v.ap = ap; v.hbl = hbl; v.bg = bg; v.bank = bank;
    v.row = row; v.col = col; v.exp = exp;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int s, input int vi);
    ddr_act[s]     = vecs[vi].cmd[0];
    ddr_pre[s]     = vecs[vi].cmd[1];
    ddr_read[s]    = vecs[vi].cmd[2];
    ddr_write[s]   = vecs[vi].cmd[3];
    ddr_ref[s]     = vecs[vi].cmd[4];
    ddr_zq[s]      = vecs[vi].cmd[5];
    ddr_pall[s]    = vecs[vi].cmd[6];
    ddr_nop[s]     = vecs[vi].nop;
    ddr_ap[s]      = vecs[vi].ap;
    ddr_half_bl[s] = vecs[vi].hbl;
    ddr_bg[s*BGW +: BGW]   = vecs[vi].bg;
    ddr_bank[s*BKW +: BKW] = vecs[vi].bank;
    ddr_row[s*RWW +: RWW]  = vecs[vi].row;
    ddr_col[s*CLW +: CLW]  = vecs[vi].col;
  endtask

  task automatic cap_beat_idx(input int i0, input int i1, input int i2, input int i3);
    int idx [4];
    idx = '{i0, i1, i2, i3};
    for (int s = 0; s < 4; s++) begin
      set_slot(s, idx[s]);
      exp_asm[tb_beat*128 + s*32 +: 32] = vecs[idx[s]].exp;
    end
    capture_en = 1'b1;
    step();
    tb_beat++;
    if (tb_beat == 4) begin
      if (push_budget > 0) begin
        sb_q.push_back({1'b0, exp_asm});
        push_budget--;
      end
      exp_asm = '0;
      tb_beat = 0;
    end
  endtask

  task automatic cap_beat(input int k);
    cap_beat_idx((k*5) % 16, (k*5 + 7) % 16, (k*3 + 11) % 16, (k + 13) % 16);
  endtask

  // retro: the window ends on a word boundary with its last word still queued.
  task automatic end_window(input bit retro);
    capture_en = 1'b0;
    for (int s = 0; s < 4; s++) set_slot(s, 9);
    if (tb_beat != 0) begin
      if (push_budget > 0) sb_q.push_back({1'b1, exp_asm});
    end else if (retro && sb_q.size() > 0) begin
      sb_q[sb_q.size()-1].last = 1'b1;
    end
    tb_beat = 0;
    exp_asm = '0;
    repeat (3) step();
  endtask

  task automatic drain();
    int t;
    t = 0;
    M_AXIS_TREADY = 1'b1;
    while (sb_q.size() != 0 && t < 200) begin
      step();
      t++;
    end
    check("drain_remaining", 512'(sb_q.size()), 512'd0);
    repeat (2) step();
    check("idle_after_drain", M_AXIS_TVALID, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", M_AXIS_TVALID, 1'b1);
        check("hold_data", M_AXIS_TDATA, prev_data);
        if (prev_last) check("hold_last", M_AXIS_TLAST, 1'b1);
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        check("word_expected", 512'(sb_q.size() != 0), 512'd1);
        if (sb_q.size() != 0) begin
          sb_e = sb_q.pop_front();
          check("word_data", M_AXIS_TDATA, sb_e.data);
          check("word_last", M_AXIS_TLAST, sb_e.last);
        end
      end
      prev_hold = M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_data = M_AXIS_TDATA;
      prev_last = M_AXIS_TLAST;
    end
  end

  initial begin
    vecs[0]  = mk(CA,           0, 0, 0, 2'd2, 2'd1, 17'h1ABCD, 10'h000, 32'h00D5E6CA);
    vecs[1]  = mk(CA|CR,        0, 1, 0, 2'd2, 2'd1, 17'h1ABCD, 10'h3FF, 32'h00D5E6CA);
    vecs[2]  = mk(CR,           0, 1, 0, 2'd0, 2'd0, 17'h1FFFF, 10'h3FF, 32'h0101FF83);
    vecs[3]  = mk(CW,           0, 0, 1, 2'd1, 2'd3, 17'h1FFFF, 10'h155, 32'h0200AABC);
    vecs[4]  = mk(CP,           0, 1, 0, 2'd3, 2'd2, 17'h1FFFF, 10'h3FF, 32'h00000071);
    vecs[5]  = mk(CF,           0, 1, 1, 2'd1, 2'd1, 17'h00000, 10'h000, 32'h0000002D);
    vecs[6]  = mk(CZ,           0, 0, 0, 2'd0, 2'd0, 17'h00000, 10'h000, 32'h00000006);
    vecs[7]  = mk(CL,           0, 0, 0, 2'd3, 2'd3, 17'h00000, 10'h000, 32'h0000007F);
    vecs[8]  = mk(7'h00,        1, 0, 0, 2'd3, 2'd3, 17'h0FFFF, 10'h3FF, 32'h00000000);
    vecs[9]  = mk(7'h00,        0, 1, 0, 2'd3, 2'd3, 17'h00001, 10'h001, 32'h00000000);
    vecs[10] = mk(CP|CR|CW,     0, 0, 0, 2'd1, 2'd0, 17'h00000, 10'h000, 32'h00000021);
    vecs[11] = mk(CR|CW,        0, 0, 1, 2'd0, 2'd1, 17'h00000, 10'h001, 32'h0200008B);
    vecs[12] = mk(CF|CZ|CL,     0, 0, 0, 2'd0, 2'd2, 17'h00000, 10'h000, 32'h00000015);
    vecs[13] = mk(CW,           0, 1, 1, 2'd0, 2'd0, 17'h00000, 10'h3FF, 32'h0301FF84);
    vecs[14] = mk(CA,           0, 0, 0, 2'd0, 2'd0, 17'h00000, 10'h000, 32'h00000002);
    vecs[15] = mk(CA,           0, 1, 1, 2'd3, 2'd3, 17'h1FFFF, 10'h3FF, 32'h00FFFFFA);

    rst_n = 1'b0; capture_en = 1'b0; M_AXIS_TREADY = 1'b0;
    for (int s = 0; s < 4; s++) set_slot(s, 9);
    tb_beat = 0; exp_asm = '0; push_budget = 1000;
    prev_hold = 1'b0; prev_last = 1'b0; prev_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", M_AXIS_TVALID, 1'b0);
    check("rst_tdata", M_AXIS_TDATA, 512'd0);
    check("rst_tlast", M_AXIS_TLAST, 1'b0);
    check("rst_words_sent", words_sent, 32'd0);
    check("rst_drop_count", drop_count, 16'd0);
    rst_n = 1'b1;
    step();

    // ACT encoding, push latency, then a 6-beat window flushed with padding.
    M_AXIS_TREADY = 1'b1;
    for (int k = 0; k < 3; k++) cap_beat_idx(0, 9, 9, 9);
    check("latency_not_early", M_AXIS_TVALID, 1'b0);
    cap_beat_idx(0, 9, 9, 9);
    check("latency_valid", M_AXIS_TVALID, 1'b1);
    check("act_slot0", 512'(M_AXIS_TDATA[31:0]), 512'h00D5E6CA);
    cap_beat_idx(1, 2, 9, 9);
    cap_beat_idx(1, 2, 9, 9);
    end_window(1'b0);
    drain();
    check("sent_after_flush", words_sent, 32'd2);

    // Table sweep: 4 full words and a 2-beat partial, continuous accept.
    for (int k = 0; k < 18; k++) cap_beat(k);
    end_window(1'b0);
    drain();
    check("sent_after_table", words_sent, 32'd7);
    check("drop_after_table", drop_count, 16'd0);

    // Window ending on a word boundary while words are still queued.
    M_AXIS_TREADY = 1'b0;
    for (int k = 0; k < 8; k++) cap_beat(k + 3);
    end_window(1'b1);
    check("retro_head_valid", M_AXIS_TVALID, 1'b1);
    check("retro_head_last", M_AXIS_TLAST, 1'b0);
    drain();
    check("sent_after_retro", words_sent, 32'd9);

    // Overflow: 7 words into a 4-deep FIFO with no accept.
    M_AXIS_TREADY = 1'b0;
    push_budget = 4;
    for (int k = 0; k < 28; k++) cap_beat(k + 1);
    end_window(1'b1);
    check("drop_overflow", drop_count, 16'd3);
    drain();
    check("sent_after_overflow", words_sent, 32'd13);
    push_budget = 1000;

    // Full FIFO with a pop on the same edge as the fifth push.
    for (int k = 0; k < 20; k++) begin
      M_AXIS_TREADY = (k == 19);
      cap_beat(k + 7);
    end
    M_AXIS_TREADY = 1'b0;
    end_window(1'b1);
    check("drop_full_pop_push", drop_count, 16'd3);
    drain();
    check("sent_after_full_pop", words_sent, 32'd18);

    // Reset in the middle of beat 2 with two words queued.
    M_AXIS_TREADY = 1'b0;
    for (int k = 0; k < 10; k++) cap_beat(k + 2);
    check("pre_reset_valid", M_AXIS_TVALID, 1'b1);
    rst_n = 1'b0;
    capture_en = 1'b0;
    sb_q.delete();
    tb_beat = 0;
    exp_asm = '0;
    step();
    check("mid_rst_tvalid", M_AXIS_TVALID, 1'b0);
    check("mid_rst_tdata", M_AXIS_TDATA, 512'd0);
    check("mid_rst_words_sent", words_sent, 32'd0);
    check("mid_rst_drop_count", drop_count, 16'd0);
    rst_n = 1'b1;
    M_AXIS_TREADY = 1'b1;
    repeat (8) step();
    check("no_stale_words", M_AXIS_TVALID, 1'b0);
    M_AXIS_TREADY = 1'b0;
    for (int k = 0; k < 4; k++) cap_beat(k + 9);
    end_window(1'b1);
    drain();
    check("sent_after_reset", words_sent, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
